// File: rtl/mult_share_arbiter.sv
// Round-robin time-sharing of one multiplier between NREQ requesters; optional WAIT timeout under MUL_TIMEOUT_EN.
// Latency: grant 1 cycle after req seen in IDLE, mul_start 1 cycle later, done 1 cycle after mul_ready sampled high.
// Backpressure: one transaction at a time; other requesters hold req until granted, and RELEASE waits for mul_ready low.
module mult_share_arbiter #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 6,
  parameter int PWIDTH  = 14,
  parameter int TIMEOUT = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   op_a,
  input  logic [NREQ*WIDTH-1:0]   op_b,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [PWIDTH-1:0]       product_out,
  output logic                    busy,
  output logic                    error,
  output logic [WIDTH-1:0]        mul_word1,
  output logic [WIDTH-1:0]        mul_word2,
  output logic                    mul_start,
  input  logic [PWIDTH-1:0]       mul_product,
  input  logic                    mul_ready
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   last;       // most recently completed requester
  logic [IW-1:0]   gidx;       // requester currently holding the multiplier
  logic [IW-1:0]   sel_idx;
  logic            sel_found;
  logic            timed_out;

  // Round-robin pick: first requesting index after 'last', wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!sel_found && req[IW'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(idx);
      end
    end
  end

`ifdef MUL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Fires in the TIMEOUT-th WAIT cycle if the multiplier still has not answered.
  assign timed_out = (state == S_WAIT) && !mul_ready && (wait_cnt == CW'(TIMEOUT - 1));

  // WAIT-cycle counter and the error pulse that accompanies a timed-out done.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      error    <= 1'b0;
    end else begin
      error <= timed_out;
      if (state == S_ISSUE)
        wait_cnt <= '0;
      else if (state == S_WAIT && wait_cnt != CW'(TIMEOUT))
        wait_cnt <= wait_cnt + CW'(1);
    end
  end
`else
  assign timed_out = 1'b0;
  assign error     = 1'b0;
`endif

  // Next-state logic; RELEASE waits for ready to drop so a stale ready is never reused.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (sel_found) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_WAIT;
      S_WAIT:    if (mul_ready || timed_out) state_next = S_RELEASE;
      S_RELEASE: if (!mul_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Datapath: operand latch, start sequencing, result capture and grant/done outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant       <= '0;
      done        <= '0;
      product_out <= '0;
      mul_word1   <= '0;
      mul_word2   <= '0;
      mul_start   <= 1'b0;
      gidx        <= '0;
      last        <= IW'(NREQ - 1);
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            gidx      <= sel_idx;
            grant     <= NREQ'(1) << sel_idx;
            mul_word1 <= op_a[sel_idx*WIDTH +: WIDTH];
            mul_word2 <= op_b[sel_idx*WIDTH +: WIDTH];
          end
        end
        S_ISSUE: mul_start <= 1'b1;
        S_WAIT: begin
          if (mul_ready || timed_out) begin
            product_out <= mul_ready ? mul_product : '0;
            done        <= grant;
            mul_start   <= 1'b0;
            last        <= gidx;
          end
        end
        S_RELEASE: grant <= '0;
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: requester and multiplier models around the DUT, transaction-level expectations.
// Expected grants follow the round-robin rule over the requests presented; products come from requester operands.
// The multiplier model answers a configurable number of cycles after start and can hold ready after start falls.
module tb_mult_share_arbiter;
  localparam int NREQ    = 2;
  localparam int WIDTH   = 6;
  localparam int PWIDTH  = 14;
  localparam int TIMEOUT = 8;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [PWIDTH-1:0]     product_out;
  logic                  busy;
  logic                  error;
  logic [WIDTH-1:0]      mul_word1;
  logic [WIDTH-1:0]      mul_word2;
  logic                  mul_start;
  logic [PWIDTH-1:0]     mul_product;
  logic                  mul_ready;

  mult_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .PWIDTH(PWIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
    .grant(grant), .done(done), .product_out(product_out), .busy(busy), .error(error),
    .mul_word1(mul_word1), .mul_word2(mul_word2), .mul_start(mul_start),
    .mul_product(mul_product), .mul_ready(mul_ready)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Requester side
  logic [NREQ-1:0]  req_r = '0;
  logic [WIDTH-1:0] ra [NREQ];
  logic [WIDTH-1:0] rb [NREQ];
  int  reqs_left [NREQ];
  int  req_rise_cyc [NREQ];
  bit  auto_rerq = 1'b0;
  bit  rand_mode = 1'b0;

  // Transaction tracking
  int  cyc = 0;
  bit  in_flight = 1'b0;
  int  cur = 0;
  int  m_last = NREQ - 1;
  int  n_done = 0;
  bit  timeout_mode = 1'b0;
  bit  chk_lat = 1'b0;
  int  grant_cyc = 0;
  int  start_cyc = 0;
  int  order [$];
  logic [NREQ-1:0] prev_grant = '0;
  logic prev_start = 1'b0;

  // Multiplier model
  int  mlat = 4;
  int  mhold_cfg = 0;
  int  mcnt = 0;
  int  mhold = 0;
  bit  mready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int lst);
    for (int k = 1; k <= NREQ; k++)
      if (r[(lst + k) % NREQ]) return (lst + k) % NREQ;
    return -1;
  endfunction

  task automatic drive();
    req = req_r;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i*WIDTH +: WIDTH] = ra[i];
      op_b[i*WIDTH +: WIDTH] = rb[i];
    end
    mul_ready   = mready;
    mul_product = mready ? PWIDTH'(32'(mul_word1) * 32'(mul_word2)) : PWIDTH'($urandom);
  endtask

  task automatic raise(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_r[i] = 1'b1;
    ra[i] = a;
    rb[i] = b;
    req_rise_cyc[i] = cyc;
    drive();
  endtask

  task automatic step();
    int e;
    @(posedge clock);
    #1;
    cyc++;
    if (grant != 0)
      chk("grant_onehot", $countones(grant), 1);
    if (grant != 0 && prev_grant == 0) begin
      e = rr_pick(req_r, m_last);
      chk("grant_pick", grant, (e < 0) ? 0 : (1 << e));
      chk("grant_overlap", in_flight, 0);
      if (e >= 0) begin
        chk("word1", mul_word1, ra[e]);
        chk("word2", mul_word2, rb[e]);
        cur = e;
        if (chk_lat) chk("lat_grant", cyc - req_rise_cyc[e], 1);
      end
      in_flight = 1'b1;
      grant_cyc = cyc;
    end
    if (mul_start && !prev_start) begin
      start_cyc = cyc;
      if (chk_lat) chk("lat_start", cyc - grant_cyc, 1);
    end
    if (done != 0) begin
      chk("done_vec", done, in_flight ? (1 << cur) : 0);
      chk("grant_incl", grant, done);
      chk("product", product_out, timeout_mode ? 0 : 32'(ra[cur]) * 32'(rb[cur]));
      chk("error", error, timeout_mode);
      chk("done_lat", cyc - start_cyc, timeout_mode ? TIMEOUT : mlat);
      order.push_back(cur);
      m_last = cur;
      in_flight = 1'b0;
      n_done++;
      req_r[cur] = 1'b0;
      if (rand_mode) begin
        mlat = $urandom_range(1, 8);
        mhold_cfg = $urandom_range(0, 2);
      end
      if (auto_rerq && reqs_left[cur] > 0) begin
        reqs_left[cur]--;
        raise(cur, WIDTH'($urandom), WIDTH'($urandom));
      end
    end
    // multiplier: ready mlat cycles after start seen, held mhold_cfg cycles after start falls
    if (mul_start) begin
      mcnt++;
      if (mcnt >= mlat) begin
        if (!mready) mhold = mhold_cfg;
        mready = 1'b1;
      end
    end else begin
      mcnt = 0;
      if (mready) begin
        if (mhold > 0) mhold--;
        else mready = 1'b0;
      end
    end
    prev_grant = grant;
    prev_start = mul_start;
    drive();
  endtask

  task automatic run_done(input int target, input int budget, input string tag);
    int n = 0;
    while (n_done < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, n_done, target);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || grant != 0) && n < 30) begin
      step();
      n++;
    end
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_r = '0;
    in_flight = 1'b0;
    mready = 1'b0;
    drive();
    step();
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_word1", mul_word1, 0);
    chk("rst_word2", mul_word2, 0);
    reset = 1'b0;
    in_flight = 1'b0;
    m_last = NREQ - 1;
    mready = 1'b0;
    mcnt = 0;
    mhold = 0;
    drive();
  endtask

  initial begin
    int base;
    int obase;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = '0;
      rb[i] = '0;
      reqs_left[i] = 0;
      req_rise_cyc[i] = 0;
    end
    reset = 1'b1;
    drive();
    step();
    do_reset();

    // 1: single request, ready six cycles after start
    mlat = 6; mhold_cfg = 0; chk_lat = 1'b1;
    base = n_done;
    raise(0, 6'd5, 6'd7);
    run_done(base + 1, 40, "t1_done");
    chk("t1_product", product_out, 35);
    chk_lat = 1'b0;
    drain();

    // 2: simultaneous requests after reset, requester 0 first
    do_reset();
    mlat = 3;
    base = n_done;
    obase = order.size();
    raise(0, 6'd3, 6'd4);
    raise(1, 6'd6, 6'd9);
    run_done(base + 2, 60, "t2_done");
    if (order.size() >= obase + 2) begin
      chk("t2_first", order[obase], 0);
      chk("t2_second", order[obase + 1], 1);
    end
    drain();

    // 3: continuous re-requests alternate
    do_reset();
    auto_rerq = 1'b1;
    mlat = $urandom_range(1, 5);
    base = n_done;
    obase = order.size();
    reqs_left[0] = 2;
    reqs_left[1] = 2;
    raise(0, WIDTH'($urandom), WIDTH'($urandom));
    raise(1, WIDTH'($urandom), WIDTH'($urandom));
    run_done(base + 6, 150, "t3_done");
    for (int k = 0; k < 6; k++)
      if (order.size() > obase + k) chk("t3_order", order[obase + k], k % 2);
    auto_rerq = 1'b0;
    drain();

    // 4: ready held after start falls, one done per transaction
    mlat = 2; mhold_cfg = 3;
    auto_rerq = 1'b1;
    base = n_done;
    reqs_left[0] = 1;
    reqs_left[1] = 1;
    raise(0, WIDTH'($urandom), WIDTH'($urandom));
    raise(1, WIDTH'($urandom), WIDTH'($urandom));
    run_done(base + 4, 120, "t4_done");
    auto_rerq = 1'b0;
    drain();
    repeat (5) step();
    chk("t4_count", n_done - base, 4);
    mhold_cfg = 0;

    // request withdrawn before grant is never served
    mlat = 10;
    base = n_done;
    raise(0, WIDTH'($urandom), WIDTH'($urandom));
    repeat (4) step();
    raise(1, WIDTH'($urandom), WIDTH'($urandom));
    repeat (3) step();
    req_r[1] = 1'b0;
    drive();
    run_done(base + 1, 40, "drop_done");
    drain();
    repeat (6) step();
    chk("drop_count", n_done - base, 1);

    // randomized traffic
    rand_mode = 1'b1;
    mlat = $urandom_range(1, 8);
    mhold_cfg = $urandom_range(0, 2);
    base = n_done;
    reqs_left[0] = 4;
    reqs_left[1] = 4;
    for (int c = 0; c < 600 && n_done < base + 8; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_r[i] && reqs_left[i] > 0 && $urandom_range(0, 2) == 0) begin
          reqs_left[i]--;
          raise(i, WIDTH'($urandom), WIDTH'($urandom));
        end
      step();
    end
    run_done(base + 8, 60, "rand_done");
    rand_mode = 1'b0;
    mhold_cfg = 0;
    drain();

    // 5: multiplier never answers
    mlat = 1000000;
    base = n_done;
    raise(0, WIDTH'($urandom), WIDTH'($urandom));
`ifdef MUL_TIMEOUT_EN
    timeout_mode = 1'b1;
    run_done(base + 1, 40, "t5_timeout");
    timeout_mode = 1'b0;
    drain();
    base = n_done;
    raise(0, WIDTH'($urandom), WIDTH'($urandom));
    repeat (5) step();
`else
    repeat (40) step();
    chk("t5_busy", busy, 1);
    chk("t5_start", mul_start, 1);
    chk("t5_nodone", n_done - base, 0);
`endif

    // 6: reset while waiting aborts, then requester 1 alone is served
    do_reset();
    repeat (3) step();
    chk("t6_nodone", n_done - base, 0);
    mlat = 3;
    base = n_done;
    obase = order.size();
    raise(1, 6'd11, 6'd13);
    run_done(base + 1, 30, "t6_done");
    if (order.size() > obase) chk("t6_who", order[obase], 1);
    chk("t6_product", product_out, 143);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
